// File: rtl/dmem_pkg.sv
// Shared widths and state encoding for the line-granular data memory.
package dmem_pkg;

   localparam int LINE_W        = 256;
   localparam int LINE_OFFSET_W = 5;
   localparam int CNT_W         = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_line_array.sv
// DEPTH x LINE_W line storage: one synchronous write port and one registered read port on a shared index.
module dmem_line_array #(
   parameter int LINE_W = 256,
   parameter int DEPTH  = 512,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx,
   input  logic              wr_en,
   input  logic [LINE_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [LINE_W-1:0] rd_data
);

   logic [LINE_W-1:0] mem [DEPTH];

   // Storage contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[idx] <= wr_data;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_line_ctrl.sv
// Fixed-latency line memory controller: captures one request, waits LATENCY edges, then acks for one cycle.
module dmem_line_ctrl #(
   parameter int LINE_W  = dmem_pkg::LINE_W,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [31:0]       addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic              busy_o
);

   import dmem_pkg::*;

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [IDX_W-1:0]   req_idx;
   logic               req_write;
   logic [LINE_W-1:0]  req_data;
   logic               access;
   logic               unused_addr;

   assign unused_addr = ^{addr_i[31:LINE_OFFSET_W+IDX_W], addr_i[LINE_OFFSET_W-1:0]};

   // The array access fires on the same edge that moves the FSM into ACK.
   assign access = (state == WAIT) && (count == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         count     <= '0;
         ack_o     <= 1'b0;
         busy_o    <= 1'b0;
         req_idx   <= '0;
         req_write <= 1'b0;
         req_data  <= '0;
      end else begin
         case (state)
            // The ACK cycle also accepts, so a held enable gives a LATENCY+1 request period.
            IDLE, ACK: begin
               ack_o <= 1'b0;
               if (enable_i) begin
                  req_idx   <= addr_i[LINE_OFFSET_W +: IDX_W];
                  req_write <= write_i;
                  req_data  <= data_i;
                  count     <= LAT_M1;
                  busy_o    <= 1'b1;
                  state     <= WAIT;
               end else begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
            end
            WAIT: begin
               if (count == '0) begin
                  ack_o  <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= ACK;
               end else begin
                  count <= count - 1'b1;
               end
            end
            default: begin
               ack_o  <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   dmem_line_array #(
      .LINE_W (LINE_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .idx     (req_idx),
      .wr_en   (access && req_write),
      .wr_data (req_data),
      .rd_en   (access && !req_write),
      .rd_data (data_o)
   );

endmodule
